// File: rtl/crc_bit_scheduler.sv
// Round-robin sequencer that shares one bit-serial inverted-CRC step engine
// between several byte-stream requesters and returns {sign, data} per message.
module crc_bit_scheduler #(
    parameter int                 p_width      = 8,
    parameter logic [p_width-1:0] p_polynom    = 8'h31,
    parameter int                 p_requesters = 4,
    parameter int                 p_idw        = (p_requesters > 1) ? $clog2(p_requesters) : 1
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [p_requesters-1:0]   req_valid,
    input  logic [8*p_requesters-1:0] req_data,
    input  logic [p_requesters-1:0]   req_last,
    output logic [p_requesters-1:0]   req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [p_width:0]          res_crc,
    output logic [p_idw-1:0]          res_id,
    output logic                      busy
);

    // Counter serves both the 8 data bits and the p_width augmentation bits.
    localparam int CW = $clog2((p_width > 8) ? p_width : 8);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, AUG, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [p_idw-1:0]  r_id, r_last_grant, w_grant;
    logic              r_s, w_s_nxt;
    logic [p_width-1:0] r_r, w_r_nxt;
    logic [7:0]        r_byte;
    logic              r_last;
    logic [CW-1:0]     r_cnt;
    logic              w_bit;
    logic              w_hs;

    assign w_hs = (r_state == LOAD) && req_valid[r_id];

    // One step of the engine: shift the new bit in, fold the polynomial when the sign is set.
    always_comb begin
        w_bit   = (r_state == SHIFT) ? r_byte[r_cnt[2:0]] : 1'b0;
        w_r_nxt = {r_r[p_width-2:0], w_bit} ^ ({p_width{r_s}} & {p_polynom[p_width-2:0], 1'b0});
        w_s_nxt = r_r[p_width-1] ^ (r_s & p_polynom[p_width-1]);
    end

    // Round-robin search starting just after the last served requester.
    always_comb begin
        int   v_idx;
        logic v_found;
        v_idx   = 0;
        v_found = 1'b0;
        w_grant = r_last_grant;
        for (int k = 1; k <= p_requesters; k++) begin
            v_idx = int'(r_last_grant) + k;
            if (v_idx >= p_requesters) v_idx = v_idx - p_requesters;
            if (!v_found && req_valid[v_idx[p_idw-1:0]]) begin
                v_found = 1'b1;
                w_grant = v_idx[p_idw-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req_valid) w_state_nxt = LOAD;
            LOAD:    if (w_hs) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0) w_state_nxt = r_last ? AUG : LOAD;
            AUG:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_id         <= '0;
            r_last_grant <= p_idw'(p_requesters - 1);
            r_s          <= 1'b0;
            r_r          <= '0;
            r_byte       <= '0;
            r_last       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: if (|req_valid) begin
                    r_id <= w_grant;
                    r_s  <= 1'b0;
                    r_r  <= '0;
                end
                LOAD: if (w_hs) begin
                    r_byte <= req_data[{r_id, 3'b000} +: 8];
                    r_last <= req_last[r_id];
                    r_cnt  <= CW'(7);
                end
                SHIFT: begin
                    r_s <= w_s_nxt;
                    r_r <= w_r_nxt;
                    // Preload the augmentation count; LOAD reloads it if more bytes follow.
                    if (r_cnt == '0) r_cnt <= CW'(p_width - 1);
                    else             r_cnt <= r_cnt - 1'b1;
                end
                AUG: begin
                    r_s   <= w_s_nxt;
                    r_r   <= w_r_nxt;
                    r_cnt <= r_cnt - 1'b1;
                end
                DONE: if (res_ready) r_last_grant <= r_id;
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == LOAD) ? (p_requesters'(1) << r_id) : '0;
    assign res_valid = (r_state == DONE);
    assign res_crc   = res_valid ? {r_s, r_r} : '0;
    assign res_id    = res_valid ? r_id : '0;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_crc_bit_scheduler.sv
// Directed + randomized bench for crc_bit_scheduler against a bit-list CRC model.
module tb_crc_bit_scheduler;

    localparam int         W = 8;
    localparam int         N = 4;
    localparam logic [7:0] P = 8'h31;

    logic           clk = 1'b0;
    logic           rstN;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           res_valid, res_ready, busy;
    logic [W:0]     res_crc;
    logic [1:0]     res_id;

    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    logic [7:0] msg [0:15];

    crc_bit_scheduler #(.p_width(W), .p_polynom(P), .p_requesters(N)) dut (
        .clk(clk), .rstN(rstN),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_id(res_id),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Model: treat {S,R} as a (W+1)-bit number; shift each message bit in and
    // subtract (xor) the polynomial whenever the bit shifted out is 1.
    function automatic logic [W:0] ref_crc(input int n);
        int v = 0;
        int s;
        for (int i = 0; i < n + 1; i++) begin
            for (int k = 7; k >= 0; k--) begin
                if (i == n && k < 8 - W) break;
                s = (v >> W) & 1;
                v = ((v << 1) & ((1 << (W + 1)) - 1)) | ((i < n) ? ((msg[i] >> k) & 1) : 0);
                if (s == 1) v = v ^ (int'(P) << 1);
            end
        end
        return v[W:0];
    endfunction

    // Drive one message on requester id; returns once res_valid is up.
    task automatic do_msg(input int id, input int n, input int gap_at, input int gap_len,
                          output logic [W:0] crc, output int rid, output int lat);
        int   start, waited;
        logic ok;
        ok = 1'b1; start = cyc; crc = 'x; rid = -1; lat = -1;
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) begin
                req_valid[id] = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (!busy || (req_ready & ~(N'(1) << id)) != '0) ok = 1'b0;
                end
                if (req_ready != (N'(1) << id)) ok = 1'b0;
            end
            req_valid[id] = 1'b1;
            req_data[8*id +: 8] = msg[b];
            req_last[id] = (b == n - 1);
            waited = 0;
            while (!req_ready[id] && waited < 100) begin @(negedge clk); waited++; end
            if (waited >= 100) begin
                chk("ready_timeout", 32'd0, 32'd1);
                req_valid[id] = 1'b0;
                return;
            end
            if (req_ready != (N'(1) << id)) ok = 1'b0;
            @(posedge clk); #1;
            req_valid[id] = 1'b0;
        end
        waited = 0;
        while (!res_valid && waited < 100) begin @(negedge clk); waited++; end
        if (waited >= 100) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        chk("grant_onehot", {31'd0, ok}, 32'd1);
        lat = cyc - start; crc = res_crc; rid = int'(res_id);
    endtask

    task automatic accept(input int delay);
        repeat (delay) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("accept_idle", {30'd0, res_valid, busy}, 32'd0);
    endtask

    initial begin
        logic [W:0] crc, c_hold;
        int         rid, lat, waited, n, id;
        logic       stable;

        rstN = 1'b0; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b0;
        #3;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_res", {22'd0, res_valid, res_crc}, 32'd0);
        chk("rst_id_busy", {29'd0, res_id, busy}, 32'd0);
        @(negedge clk); rstN = 1'b1; @(negedge clk);

        // Single byte 0x01 from requester 0.
        msg[0] = 8'h01;
        do_msg(0, 1, -1, 0, crc, rid, lat);
        chk("t1_crc", 32'(crc), 32'h100);
        chk("t1_id", rid, 0);
        chk("t1_lat", lat, 1 + 9 + W);
        accept(0);

        // Single byte 0x80 from requester 2.
        msg[0] = 8'h80;
        do_msg(2, 1, -1, 0, crc, rid, lat);
        chk("t2_crc", 32'(crc), 32'h07A);
        chk("t2_id", rid, 2);
        accept(1);

        // Message from id 1, then ids 1 and 3 contend: 3 must win.
        msg[0] = 8'h5A; msg[1] = 8'hC3;
        do_msg(1, 2, -1, 0, crc, rid, lat);
        chk("t3a_crc", 32'(crc), 32'(ref_crc(2)));
        chk("t3a_lat", lat, 1 + 18 + W);
        accept(0);
        req_valid[1] = 1'b1; req_data[15:8] = 8'h11; req_last[1] = 1'b1;
        msg[0] = 8'hE7;
        do_msg(3, 1, -1, 0, crc, rid, lat);
        chk("t3b_crc", 32'(crc), 32'(ref_crc(1)));
        chk("t3b_id", rid, 3);
        // Consumer stalls for 10 cycles while requester 1 waits.
        c_hold = crc; stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!res_valid || res_crc !== c_hold || res_id !== 2'd3 || !busy || req_ready !== '0)
                stable = 1'b0;
        end
        chk("t4_stall_stable", {31'd0, stable}, 32'd1);
        accept(0);
        msg[0] = 8'h11;
        do_msg(1, 1, -1, 0, crc, rid, lat);
        chk("t3c_id", rid, 1);
        chk("t3c_crc", 32'(crc), 32'(ref_crc(1)));
        accept(0);

        // Three-byte message with valid dropped before the third byte; id 0 waits meanwhile.
        req_valid[0] = 1'b1; req_data[7:0] = 8'h42; req_last[0] = 1'b1;
        msg[0] = 8'hDE; msg[1] = 8'hAD; msg[2] = 8'hBE;
        do_msg(2, 3, 2, 13, crc, rid, lat);
        chk("t5_crc", 32'(crc), 32'(ref_crc(3)));
        chk("t5_id", rid, 2);
        accept(0);
        msg[0] = 8'h42;
        do_msg(0, 1, -1, 0, crc, rid, lat);
        chk("t5b_crc", 32'(crc), 32'(ref_crc(1)));
        accept(0);

        // Reset in the middle of the second byte's SHIFT phase.
        req_valid[1] = 1'b1; req_data[15:8] = 8'hA5; req_last[1] = 1'b0;
        waited = 0;
        while (!req_ready[1] && waited < 50) begin @(negedge clk); waited++; end
        @(posedge clk); #1;
        req_data[15:8] = 8'h3C; req_last[1] = 1'b1;
        while (!req_ready[1] && waited < 50) begin @(negedge clk); waited++; end
        chk("t6_reach_shift", {31'd0, (waited < 50)}, 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_res", {22'd0, res_valid, res_crc}, 32'd0);
        chk("t6_rst_id_busy", {29'd0, res_id, busy}, 32'd0);
        @(negedge clk); rstN = 1'b1; @(negedge clk);
        // After reset requester 0 must win over 2.
        req_valid[2] = 1'b1; req_data[23:16] = 8'h99; req_last[2] = 1'b1;
        msg[0] = 8'h3C; msg[1] = 8'h0F;
        do_msg(0, 2, -1, 0, crc, rid, lat);
        chk("t6_crc", 32'(crc), 32'(ref_crc(2)));
        chk("t6_id", rid, 0);
        accept(0);
        msg[0] = 8'h99;
        do_msg(2, 1, -1, 0, crc, rid, lat);
        chk("t6b_crc", 32'(crc), 32'(ref_crc(1)));
        accept(0);

        // Randomized messages.
        for (int it = 0; it < 16; it++) begin
            id = int'($urandom_range(0, N - 1));
            n  = int'($urandom_range(1, 5));
            for (int b = 0; b < n; b++) msg[b] = 8'($urandom);
            do_msg(id, n, -1, 0, crc, rid, lat);
            chk("rnd_crc", 32'(crc), 32'(ref_crc(n)));
            chk("rnd_id", rid, id);
            chk("rnd_lat", lat, 1 + 9 * n + W);
            accept(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
